// File: rtl/fsmc_bus_ctrl_pkg.sv
// rtl/fsmc_bus_ctrl_pkg.sv - bus width, FSM state encodings and timeout fill value for fsmc_bus_ctrl
// Purpose : holds the FSMC data width, the 3-bit sequencer state encodings
//           (FBC_IDLE .. FBC_RD_DRIVE) and the data returned on a timed-out read.
// Ports   : none (package).
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif
`ifndef FBC_IDLE
`define FBC_IDLE     3'd0
`define FBC_WR_DATA  3'd1
`define FBC_WR_REQ   3'd2
`define FBC_RD_REQ   3'd3
`define FBC_RD_SETUP 3'd4
`define FBC_RD_DRIVE 3'd5
`endif
`ifndef FBC_TIMEOUT_FILL
`define FBC_TIMEOUT_FILL {`FSMC_WIDTH{1'b1}}
`endif

package fsmc_bus_ctrl_pkg;

    localparam int DATA_W = `FSMC_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = `FBC_IDLE,
        ST_WR_DATA  = `FBC_WR_DATA,
        ST_WR_REQ   = `FBC_WR_REQ,
        ST_RD_REQ   = `FBC_RD_REQ,
        ST_RD_SETUP = `FBC_RD_SETUP,
        ST_RD_DRIVE = `FBC_RD_DRIVE
    } fbc_state_t;

    localparam logic [DATA_W-1:0] TIMEOUT_FILL = `FBC_TIMEOUT_FILL;

endpackage

// File: rtl/fsmc_sync.sv
// rtl/fsmc_sync.sv - single-bit multi-stage synchroniser presetting to 1 on reset
// Purpose : brings one asynchronous active-low FSMC strobe into the clk domain.
// Ports   : i_clk, i_rst (async, active high), i_d (async strobe), o_q (synchronised).
module fsmc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Preset to 1 so every strobe looks inactive straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/fsmc_bus_ctrl.sv
// rtl/fsmc_bus_ctrl.sv - FSMC strobe decoder and register-file handshake sequencer
// Purpose : synchronises NE/NOE/NWE, decodes host read/write cycles, runs the
//           req/ack handshake with timeout, and sequences the data buffer so data
//           is loaded one cycle before OE rises.
// Ports   : i_clk/i_rst, FSMC strobes i_fsmc_ne/noe/nwe and address i_fsmc_a,
//           buffer side i_bus_din/o_bus_dout/o_bus_oe, register-file side
//           o_reg_addr/o_reg_wdata/o_reg_wr/o_reg_rd/i_reg_rdata/i_reg_ack,
//           status o_err_timeout and host wait o_fsmc_nwait.
// Macro   : FSMC_NWAIT_EN enables the host wait output; otherwise it is tied to 1.
module fsmc_bus_ctrl
    import fsmc_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fsmc_ne,
    input  logic              i_fsmc_noe,
    input  logic              i_fsmc_nwe,
    input  logic [ADDR_W-1:0] i_fsmc_a,
    input  logic [DATA_W-1:0] i_bus_din,
    output logic [DATA_W-1:0] o_bus_dout,
    output logic              o_bus_oe,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic [DATA_W-1:0] i_reg_rdata,
    input  logic              i_reg_ack,
    output logic              o_err_timeout,
    output logic              o_fsmc_nwait
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic w_ne_s, w_noe_s, w_nwe_s;
    logic r_ne_d, r_noe_d, r_nwe_d;
    logic w_noe_fall, w_nwe_rise, w_ne_rise;
    logic w_rd_start, w_wr_start, w_req, w_expire, w_abort;

    fbc_state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_shadow, r_dout;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_abort;
    logic              r_err;

    fsmc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ne  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_fsmc_ne),  .o_q(w_ne_s));
    fsmc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_noe (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_fsmc_noe), .o_q(w_noe_s));
    fsmc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nwe (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_fsmc_nwe), .o_q(w_nwe_s));

    assign w_noe_fall = r_noe_d & ~w_noe_s;
    assign w_nwe_rise = ~r_nwe_d & w_nwe_s;
    assign w_ne_rise  = ~r_ne_d & w_ne_s;

    // Read wins over a simultaneous write because it is tested first here and in IDLE.
    assign w_rd_start = (r_state == ST_IDLE) & ~w_ne_s & w_noe_fall;
    assign w_wr_start = (r_state == ST_WR_DATA) & (w_nwe_rise | w_ne_rise);
    assign w_req      = (r_state == ST_RD_REQ) | (r_state == ST_WR_REQ);
    // Expiry is masked by ack so an ack in the final cycle is still honoured.
    assign w_expire   = w_req & ~i_reg_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
    // A host that dropped NE mid-read still gets the handshake finished, but no drive.
    assign w_abort    = r_abort | w_ne_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_start) begin
                    w_next = ST_RD_REQ;
                end else if (~w_ne_s & ~w_nwe_s) begin
                    w_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA:  if (w_wr_start) w_next = ST_WR_REQ;
            ST_WR_REQ:   if (i_reg_ack | w_expire) w_next = ST_IDLE;
            ST_RD_REQ:   if (i_reg_ack | w_expire) w_next = w_abort ? ST_IDLE : ST_RD_SETUP;
            ST_RD_SETUP: w_next = ST_RD_DRIVE;
            ST_RD_DRIVE: if (w_noe_s | w_ne_s) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Decoded from the state register so reset clears them asynchronously.
    always_comb begin
        o_bus_oe = (r_state == ST_RD_DRIVE);
        o_reg_rd = (r_state == ST_RD_REQ);
        o_reg_wr = (r_state == ST_WR_REQ);
`ifdef FSMC_NWAIT_EN
        o_fsmc_nwait = ~(w_rd_start | (r_state == ST_RD_REQ) | (r_state == ST_RD_SETUP)
                         | (r_state == ST_WR_REQ));
`else
        o_fsmc_nwait = 1'b1;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ne_d   <= 1'b1;
            r_noe_d  <= 1'b1;
            r_nwe_d  <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_shadow <= '0;
            r_dout   <= '0;
            r_cnt    <= '0;
            r_abort  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ne_d  <= w_ne_s;
            r_noe_d <= w_noe_s;
            r_nwe_d <= w_nwe_s;
            r_err   <= w_expire;
            // Shadow tracks the bus while NWE is low; the value from before the
            // release edge is the one committed, as the bus may already be changing.
            if (r_state == ST_WR_DATA) begin
                r_shadow <= i_bus_din;
            end
            if (w_rd_start | w_wr_start) begin
                r_addr <= i_fsmc_a;
                r_cnt  <= '0;
            end else if (w_req & ~i_reg_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_wr_start) begin
                r_wdata <= r_shadow;
            end
            if (w_rd_start) begin
                r_abort <= 1'b0;
            end else if ((r_state == ST_RD_REQ) & w_ne_s) begin
                r_abort <= 1'b1;
            end
            if ((r_state == ST_RD_REQ) & i_reg_ack) begin
                r_dout <= i_reg_rdata;
            end else if ((r_state == ST_RD_REQ) & w_expire) begin
                r_dout <= TIMEOUT_FILL;
            end
        end
    end

    assign o_bus_dout    = r_dout;
    assign o_reg_addr    = r_addr;
    assign o_reg_wdata   = r_wdata;
    assign o_err_timeout = r_err;

endmodule

// File: doc/fsmc_bus_ctrl.md
Name: fsmc_bus_ctrl

Overview:
- Sequencer for the FSMC bidirectional data buffer (`FSMC_WIDTH`-bit bus, registered in/out, combinational OE).
- Synchronises the external NE/NOE/NWE strobes to `clk` and decodes read and write cycles.
- Runs a req/ack handshake to the internal register file.
- Drives the buffer's `oe` and `inp` with correct setup: data is loaded one cycle before OE rises.

Parameters:
- ADDR_W, 8, FSMC address width latched per access.
- SYNC_STAGES, 2, flip-flop stages on each FSMC strobe (min 2).
- TIMEOUT, 15, maximum `clk` cycles to wait for `reg_ack` before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fsmc_ne  in  1  chip select, active low, asynchronous
- fsmc_noe  in  1  output enable, active low, asynchronous
- fsmc_nwe  in  1  write enable, active low, asynchronous
- fsmc_a  in  ADDR_W  address from host, stable while ne low
- bus_din  in  `FSMC_WIDTH`  sampled bus value (buffer outp)
- bus_dout  out  `FSMC_WIDTH`  data to buffer inp
- bus_oe  out  1  buffer output enable
- reg_addr  out  ADDR_W  register-file address
- reg_wdata  out  `FSMC_WIDTH`  register-file write data
- reg_wr  out  1  write request, held until ack
- reg_rd  out  1  read request, held until ack
- reg_rdata  in  `FSMC_WIDTH`  register-file read data, valid with ack
- reg_ack  in  1  one-cycle acknowledge
- err_timeout  out  1  one-cycle pulse on handshake abort
- fsmc_nwait  out  1  host wait, active low (see Optional Feature)

Behaviour:
- Reset state: all outputs 0 except `fsmc_nwait`=1; FSM in IDLE; synchronisers preset to 1 (inactive).
- Synchronisation and edge detect:
  - `ne_s`, `noe_s` and `nwe_s` are SYNC_STAGES-deep synchronised copies of the strobes.
  - Edges are detected on the last stage against a one-cycle-delayed copy.
- IDLE:
  - `ne_s`=0 and `noe_s` falling: latch `fsmc_a` into `reg_addr`, assert `reg_rd`, go to RD_REQ.
  - `ne_s`=0 and `nwe_s`=0: go to WR_DATA.
- WR_DATA:
  - Shadow register takes `bus_din` every cycle.
  - On `nwe_s` rising or `ne_s` rising: latch `fsmc_a` into `reg_addr`, copy shadow into `reg_wdata`, assert `reg_wr`, go to WR_REQ.
  - Host must hold data ≥ SYNC_STAGES+2 cycles before releasing nwe.
- WR_REQ:
  - On `reg_ack`: drop `reg_wr`, go to IDLE.
- RD_REQ:
  - On `reg_ack`: drop `reg_rd`, load `reg_rdata` into `bus_dout`, go to RD_SETUP.
- RD_SETUP:
  - One cycle; the buffer's internal register now holds `bus_dout`.
  - Assert `bus_oe`, go to RD_DRIVE.
- RD_DRIVE:
  - Hold `bus_oe`=1 and `bus_dout` stable.
  - On `noe_s`=1 or `ne_s`=1: `bus_oe`=0, go to IDLE.
- Timeout:
  - A counter is cleared on entry to RD_REQ or WR_REQ and increments each cycle without ack.
  - When the count reaches TIMEOUT: drop the request and pulse `err_timeout`.
  - Read case: load all-ones into `bus_dout`, go to RD_SETUP.
  - Write case: go to IDLE; the write is discarded.
- Ack handling:
  - `reg_ack` arriving in the same cycle as the timeout takes priority over the timeout.
  - `reg_ack` in IDLE or any non-REQ state is ignored.
- Host aborts a read (`ne_s` high) while in RD_REQ:
  - Keep waiting for ack or timeout so the handshake completes.
  - Then return to IDLE without asserting `bus_oe`.
- Simultaneous `noe_s` and `nwe_s` low in IDLE: the read takes priority.
- Reset mid-access: immediate return to IDLE; `bus_oe`=0 asynchronously; requests dropped.
- Latency:
  - Read: noe fall to bus driven = SYNC_STAGES + 1 (edge) + ack wait + 2 cycles.
  - Write: nwe rise to `reg_wr` = SYNC_STAGES + 1 cycles.

Optional Feature:
- Macro: FSMC_NWAIT_EN.
- With the macro defined: `fsmc_nwait` is driven 0 combinationally when `ne`/`noe` are detected low, and held 0 until the cycle `bus_oe` rises.
- `fsmc_nwait` is also held 0 during WR_REQ.
- Without the macro: `fsmc_nwait` is tied to 1, and the host relies on fixed FSMC timing.

Decomposition:
- define.v holds `FSMC_WIDTH`, the FSM state encodings (`FBC_IDLE` … `FBC_RD_DRIVE`, 3 bits) and the timeout fill value.
- Sub-module `fsmc_sync`: per-bit SYNC_STAGES synchroniser with preset-to-1 on `rst`, instantiated for ne, noe and nwe.

Test Plan:
- Write: ne=0, fsmc_a=0x12, bus=0xA5, nwe low 8 cycles then high; ack 2 cycles later -> `reg_wr` with `reg_addr`=0x12, `reg_wdata`=0xA5, one request only.
- Read: ne=0, noe low, fsmc_a=0x34; ack with `reg_rdata`=0x5A after 3 cycles -> `bus_dout`=0x5A a cycle before `bus_oe`=1; `bus_oe` drops within SYNC_STAGES+1 cycles of noe rise.
- Read timeout: no ack -> after 15 cycles `err_timeout` pulses once, `bus_dout`=all-ones, `bus_oe` asserted.
- Ack and timeout in the same cycle -> `reg_rdata` is used and `err_timeout` stays 0.
- `rst` asserted during RD_DRIVE -> `bus_oe`=0 immediately, FSM in IDLE, no request outstanding.
- With FSMC_NWAIT_EN: `fsmc_nwait` is low from noe detection to `bus_oe` rise. Without the macro: `fsmc_nwait` is constant 1.
